clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Multi-channel, runtime-programmable clock-enable generator for the CPU system clock domain. Each of CH channels divides `sysclk` by its own programmable divisor D and emits a one-cycle enable pulse every D cycles. It supports per-channel gating and global phase alignment, and can optionally emit a ~50%-duty divided waveform. Peripherals such as LED/DIGI scanning and UART baud ticks consume these enables instead of running on derived clocks.

## Interface
Parameters:
- `CH`, 4: number of channels (1..16).
- `W`, 16: divisor/counter width in bits.
- `DEFAULT_DIV`, 2: divisor loaded into every channel at reset. Must fit in W bits.

Ports:
- `sysclk`  in  1: the only clock. All logic is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `ch_en`  in  CH: per-channel run enable.
- `sync`  in  1: global phase-align strobe.
- `wr_en`  in  1: divisor write strobe.
- `wr_ch`  in  4: target channel for the write.
- `wr_div`  in  W: new divisor value.
- `rd_ch`  in  4: channel selected for readback.
- `rd_div`  out  W: combinational readback of `div[rd_ch]`. Reads 0 if `rd_ch` >= CH.
- `pulse`  out  CH: registered enable pulses.
- `clk_sq`  out  CH: registered square outputs (see Configuration).

## Operation
Per-channel state:
- `div[c]` (W bits)
- `cnt[c]` (W bits)
- `pulse[c]`
- `clk_sq[c]`

Effective divisor: Deff = max(div[c], 1). D=0 behaves as D=1.

Reset (async) sets, for every channel:
- `div` = DEFAULT_DIV
- `cnt` = 0
- `pulse` = 0
- `clk_sq` = 0

Per channel, each edge, evaluated in priority order:
1. `sync`=1: `cnt`<=0, `pulse`<=0, `clk_sq`<=0. Applies to all channels.
2. Write hit (`wr_en`=1, `wr_ch`==c): `div`<=`wr_div`, `cnt`<=0, `pulse`<=0, `clk_sq`<=0.
3. `ch_en[c]`=0: `cnt`<=0, `pulse`<=0, `clk_sq`<=0. Divisor is retained.
4. Running, `cnt`==Deff-1: `cnt`<=0, `pulse`<=1, `clk_sq`<=1.
5. Running, otherwise: `cnt`<=`cnt`+1, `pulse`<=0. `clk_sq`<=0 if `cnt`==ceil(Deff/2)-1, else `clk_sq` holds.

Additional rules:
- A write and `sync` in the same cycle: the divisor is still written, and all counters clear.
- A write with `wr_ch` >= CH is ignored, with no side effects.
- Counter arithmetic is W-bit unsigned. `cnt` never exceeds Deff-1, so there is no wrap-around other than the explicit return to 0.
- `pulse` duty is exactly 1 cycle in every D. For D=1, `pulse` is held high continuously while running.

## Timing
- First `pulse` occurs at the D-th running edge after reset release, write, `sync`, or `ch_en` rise. Subsequent pulses follow every D edges.
- Example, D=2 from reset: `pulse` is low at edge 1, high at edge 2, low at edge 3, high at edge 4.
- A write takes effect immediately. The counter restarts in the write cycle; no partial old period completes.
- Dropping `ch_en` mid-period: `pulse` goes low at the next edge, and the phase is lost.
- Asserting `reset` mid-period: all outputs go to 0 asynchronously, and `div` returns to DEFAULT_DIV.
- `rd_div` has zero-cycle latency and reflects a write from the following cycle onward.

## Configuration
- `CLK_EN_GEN_SQUARE_EN` defined: the `clk_sq` logic is compiled in.
  - `clk_sq` rises on the same edge as `pulse`.
  - High for ceil(D/2) cycles, low for floor(D/2) cycles.
  - D=1: held 1 while running.
- `CLK_EN_GEN_SQUARE_EN` undefined: `clk_sq` is tied to all zeros, and no `clk_sq` registers are synthesised. `pulse` behaviour is identical in both builds.

## Test plan
- **Reset default:** CH=4, DEFAULT_DIV=2, `ch_en`=4'hF, release `reset` -> every `pulse` bit is high on edges 2, 4, 6, …; `rd_div`=2 for `rd_ch`=0..3.
- **Programmable divisor:** write D=5 to ch1 -> `pulse[1]` high at edges 5, 10, 15 after the write; `clk_sq[1]` high 3 cycles, low 2 (square build); ch0 unaffected.
- **D=0 and D=1:** write 0 to ch2, then 1 to ch3 -> `pulse[2]` and `pulse[3]` high every running cycle; `clk_sq` held 1.
- **Sync alignment:** ch0 D=3, ch1 D=6 at arbitrary phase, pulse `sync` -> both channels pulse together 3 and 6 edges later, then coincide every 6 edges.
- **Gating and boundaries:** drop `ch_en[0]` mid-period -> `pulse[0]` is 0 the next edge and restarts after a full D. Write to `wr_ch`=7 -> no change. `wr_en` together with `sync` -> divisor updated and all counters cleared.
- **Async reset mid-run:** assert `reset` between edges -> `pulse`=0 and `clk_sq`=0 immediately; `div` returns to DEFAULT_DIV.

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel, runtime-programmable clock-enable generator.
//
// Each channel divides sysclk by its own divisor D. It emits a one-cycle
// enable pulse every D cycles. D=0 is treated as D=1. The channel supports
// per-channel gating, a global phase-align strobe (sync) and a combinational
// divisor readback.
//
// Optional feature: define CLK_EN_GEN_SQUARE_EN to compile in the ~50%-duty
// clk_sq outputs. The square wave rises with pulse, stays high for ceil(D/2)
// cycles and then low for floor(D/2) cycles. When the macro is undefined,
// clk_sq is tied to zero and has no registers behind it.
module clk_en_gen #(
  parameter int CH          = 4,   // number of channels, 1..16
  parameter int W           = 16,  // divisor / counter width
  parameter int DEFAULT_DIV = 2    // divisor loaded at reset
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic [CH-1:0] ch_en,
  input  logic          sync,
  input  logic          wr_en,
  input  logic [3:0]    wr_ch,
  input  logic [W-1:0]  wr_div,
  input  logic [3:0]    rd_ch,
  output logic [W-1:0]  rd_div,
  output logic [CH-1:0] pulse,
  output logic [CH-1:0] clk_sq
);

  localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE     = W'(1);

  // Per-channel divisor and phase counter
  logic [W-1:0] div_q [CH];
  logic [W-1:0] div_d [CH];
  logic [W-1:0] cnt_q [CH];
  logic [W-1:0] cnt_d [CH];

  // Per-channel decode
  logic [W-1:0]  deff [CH];  // effective divisor, never 0
  logic [CH-1:0] wr_hit;     // this channel is the write target
  logic [CH-1:0] clr;        // sync, write or gated: restart the phase
  logic [CH-1:0] wrap;       // last count of the period
  logic [CH-1:0] pulse_d;

  // Decode effective divisor, restart conditions and the end of the period
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      deff[c]   = (div_q[c] == '0) ? ONE : div_q[c];
      // wr_ch values >= CH never match a channel index, so those writes are dropped
      wr_hit[c] = wr_en && (wr_ch == 4'(c));
      clr[c]    = sync || wr_hit[c] || !ch_en[c];
      wrap[c]   = (cnt_q[c] == deff[c] - ONE);
    end
  end

  // Next-state logic: sync / write / gate take priority over counting
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      // A write still lands when it coincides with sync; only the counters clear
      div_d[c] = wr_hit[c] ? wr_div : div_q[c];
      if (clr[c]) begin
        cnt_d[c]   = '0;
        pulse_d[c] = 1'b0;
      end else if (wrap[c]) begin
        cnt_d[c]   = '0;
        pulse_d[c] = 1'b1;
      end else begin
        cnt_d[c]   = cnt_q[c] + ONE;
        pulse_d[c] = 1'b0;
      end
    end
  end

  // State registers for divisor, counter and pulse
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      // NOTE: div is a small configuration register array rather than a RAM,
      // so every entry is reset to a known divisor.
      for (int c = 0; c < CH; c++) begin
        div_q[c] <= DIV_RST;
        cnt_q[c] <= '0;
      end
      pulse <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, whatever order the statements are written in.
      for (int c = 0; c < CH; c++) begin
        div_q[c] <= div_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      pulse <= pulse_d;
    end
  end

  // Readback mux: zero for channels that do not exist
  always_comb begin
    // NOTE: the default assignment first means no path leaves rd_div
    // unassigned, so no latch is inferred.
    rd_div = '0;
    for (int c = 0; c < CH; c++) begin
      if (rd_ch == 4'(c)) rd_div = div_q[c];
    end
  end

`ifdef CLK_EN_GEN_SQUARE_EN
  logic [CH-1:0] half;  // count at which the high phase ends
  logic [CH-1:0] sq_d;

  // Square wave: set with the pulse, cleared after ceil(Deff/2) high cycles
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      // ceil(Deff/2)-1 == (Deff-1)>>1
      half[c] = (cnt_q[c] == ((deff[c] - ONE) >> 1));
      if (clr[c])       sq_d[c] = 1'b0;
      else if (wrap[c]) sq_d[c] = 1'b1;
      else if (half[c]) sq_d[c] = 1'b0;
      else              sq_d[c] = clk_sq[c];
    end
  end

  // Square-wave registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) clk_sq <= '0;
    else       clk_sq <= sq_d;
  end
`else
  assign clk_sq = '0;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed self-checking bench for clk_en_gen (CH=4, W=16,
// DEFAULT_DIV=2). Expected clk_sq values follow the square-enable macro.
module tb_clk_en_gen;

`ifdef CLK_EN_GEN_SQUARE_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset;
  logic [3:0]  ch_en;
  logic        sync;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [15:0] wr_div;
  logic [3:0]  rd_ch;
  logic [15:0] rd_div;
  logic [3:0]  pulse;
  logic [3:0]  clk_sq;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected divisor and phase offset of each channel for the run task
  int d_m [4];
  int ph  [4];

  always #5 sysclk = ~sysclk;

  clk_en_gen #(.CH(4), .W(16), .DEFAULT_DIV(2)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .ch_en  (ch_en),
    .sync   (sync),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .rd_ch  (rd_ch),
    .rd_div (rd_div),
    .pulse  (pulse),
    .clk_sq (clk_sq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // k = running edges since the phase restart (1 = first edge)
  function automatic logic exp_pulse(input int k, input int d);
    int de = (d == 0) ? 1 : d;
    return (k >= 1) && ((k % de) == 0);
  endfunction

  function automatic logic exp_sq(input int k, input int d);
    int de = (d == 0) ? 1 : d;
    return SQ && (k >= de) && ((k % de) < (de + 1) / 2);
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_d(input int a, input int b, input int c, input int e);
    d_m[0] = a; d_m[1] = b; d_m[2] = c; d_m[3] = e;
  endtask

  task automatic set_ph(input int a, input int b, input int c, input int e);
    ph[0] = a; ph[1] = b; ph[2] = c; ph[3] = e;
  endtask

  // Run n edges and compare the masked pulse / clk_sq bits after each one
  task automatic run(input string tag, input int n, input logic [3:0] mask);
    logic [3:0] ep;
    logic [3:0] es;
    for (int i = 1; i <= n; i++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        ep[c] = exp_pulse(i + ph[c], d_m[c]);
        es[c] = exp_sq(i + ph[c], d_m[c]);
      end
      check($sformatf("%s_pulse_e%0d", tag, i), 32'(pulse & mask), 32'(ep & mask));
      check($sformatf("%s_sq_e%0d", tag, i), 32'(clk_sq & mask), 32'(es & mask));
    end
  endtask

  task automatic write_div(input logic [3:0] ch, input logic [15:0] v, input logic with_sync);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = v;
    sync   = with_sync;
    tick();
    wr_en  = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [3:0] ch, input logic [15:0] exp);
    rd_ch = ch;
    #1;
    check($sformatf("%s_rd%0d", tag, ch), 32'(rd_div), 32'(exp));
  endtask

  initial begin
    reset  = 1'b1;
    ch_en  = 4'hF;
    sync   = 1'b0;
    wr_en  = 1'b0;
    wr_ch  = 4'd0;
    wr_div = 16'd0;
    rd_ch  = 4'd0;

    // Reset default
    #2;
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_sq", 32'(clk_sq), 32'h0);
    for (int c = 0; c < 4; c++) check_rd("rst", 4'(c), 16'd2);
    check_rd("rst_oob", 4'd7, 16'd0);
    tick();
    #2;
    reset = 1'b0;
    set_d(2, 2, 2, 2);
    set_ph(0, 0, 0, 0);
    run("dflt", 6, 4'hF);

    // Programmable divisor: D=5 on ch1, others keep running
    write_div(4'd1, 16'd5, 1'b0);
    check_rd("wr5", 4'd1, 16'd5);
    set_d(2, 5, 2, 2);
    set_ph(1, 0, 1, 1);
    run("div5", 15, 4'hF);

    // D=0 on ch2, D=1 on ch3
    write_div(4'd2, 16'd0, 1'b0);
    write_div(4'd3, 16'd1, 1'b0);
    check_rd("d0", 4'd2, 16'd0);
    set_d(2, 5, 1, 1);
    set_ph(18, 17, 1, 0);
    run("d01", 4, 4'hF);

    // Sync alignment: ch0 D=3, ch1 D=6 at arbitrary phase
    write_div(4'd0, 16'd3, 1'b0);
    write_div(4'd1, 16'd6, 1'b0);
    repeat (4) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_pulse", 32'(pulse), 32'h0);
    check("sync_sq", 32'(clk_sq), 32'h0);
    set_d(3, 6, 1, 1);
    set_ph(0, 0, 0, 0);
    run("sync", 12, 4'hF);

    // Gating: drop ch_en[0] just after a pulse, while clk_sq[0] is high
    ch_en = 4'b1110;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("gate_pulse_e%0d", i), 32'(pulse[0]), 32'h0);
      check($sformatf("gate_sq_e%0d", i), 32'(clk_sq[0]), 32'h0);
    end
    ch_en = 4'hF;
    set_ph(0, 0, 0, 0);
    run("ungate", 6, 4'b0001);

    // Out-of-range write target: no divisor change, no phase restart
    write_div(4'd7, 16'd9, 1'b0);
    check_rd("oob", 4'd0, 16'd3);
    check_rd("oob", 4'd1, 16'd6);
    check_rd("oob", 4'd2, 16'd0);
    check_rd("oob", 4'd3, 16'd1);
    set_ph(1, 0, 0, 0);
    run("oob", 5, 4'b0001);

    // Write together with sync: divisor lands, every counter clears
    write_div(4'd1, 16'd4, 1'b1);
    check("wrsync_pulse", 32'(pulse), 32'h0);
    check_rd("wrsync", 4'd1, 16'd4);
    set_d(3, 4, 1, 1);
    set_ph(0, 0, 0, 0);
    run("wrsync", 8, 4'hF);

    // Async reset between edges
    tick();
    check("pre_rst_pulse", 32'(pulse[3:2]), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pulse", 32'(pulse), 32'h0);
    check("arst_sq", 32'(clk_sq), 32'h0);
    for (int c = 0; c < 4; c++) check_rd("arst", 4'(c), 16'd2);
    reset = 1'b0;
    set_d(2, 2, 2, 2);
    set_ph(0, 0, 0, 0);
    run("post_rst", 4, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
